// File: rtl/gray_frame_ctrl.sv
// rtl/gray_frame_ctrl.sv - frame sequencer with two-stage RGB-to-gray pipeline and stream handshakes
module gray_frame_ctrl #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pixels,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    input  logic [23:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_in_cnt;
    logic [CNT_W-1:0] r_out_cnt;

    logic [17:0]      r_s1_sum;
    logic             r_s1_valid;
    logic             r_s1_last;
    logic [7:0]       r_s2_data;
    logic             r_s2_valid;
    logic             r_s2_last;

    logic             w_adv;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_start_acc;
    logic [17:0]      w_sum;

    // Whole pipeline advances together; a held output freezes both stages.
    assign w_adv       = !r_s2_valid || out_ready;
    assign in_ready    = (r_state == RUN) && (r_in_cnt < r_n) && w_adv;
    assign w_in_hs     = in_valid && in_ready;
    assign w_out_hs    = r_s2_valid && out_ready;
    assign w_start_acc = (r_state == IDLE) && start;

    // Weighted luminance numerator; worst case 255*1000 fits in 18 bits.
    assign w_sum = 18'(in_data[7:0])   * 18'd299
                 + 18'(in_data[15:8])  * 18'd587
                 + 18'(in_data[23:16]) * 18'd114;

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_last  = r_s2_last;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: empty frames go straight to DONE, otherwise finish on the last output handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (num_pixels == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_out_hs && (r_out_cnt == r_n - CNT_W'(1))) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Frame length latch and input/output pixel counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n       <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (w_start_acc) begin
            r_n       <= num_pixels;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_in_hs) begin
                r_in_cnt <= r_in_cnt + CNT_W'(1);
            end
            if (w_out_hs) begin
                r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1 captures the weighted sum and whether this is the frame's final pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_sum   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            if (w_in_hs) begin
                r_s1_sum  <= w_sum;
                r_s1_last <= (r_in_cnt == r_n - CNT_W'(1));
            end
            if (w_adv) begin
                r_s1_valid <= w_in_hs;
            end
        end
    end

    // Stage 2 divides down to the 8-bit gray value and holds it while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else if (w_adv) begin
            r_s2_data  <= 8'(r_s1_sum / 18'd1000);
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last && r_s1_valid;
        end
    end

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// tb/tb_gray_frame_ctrl.sv - directed self-checking bench for gray_frame_ctrl
module tb_gray_frame_ctrl;

    localparam int CNT_W = 20;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_pixels;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic [23:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_last;
    logic             out_ready;

    int n_chk;
    int n_fail;

    logic [23:0] spix [16];
    logic [23:0] bpix [8];

    gray_frame_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_pixels (num_pixels),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gray_of(input logic [23:0] px);
        int r, g, b;
        r = int'(px[7:0]);
        g = int'(px[15:8]);
        b = int'(px[23:16]);
        return 8'((r * 299 + g * 587 + b * 114) / 1000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_single(input string tag, input logic [23:0] px, input logic [7:0] exp);
        @(negedge clk);
        start = 1'b1;
        num_pixels = 20'd1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy1"}, 32'(busy), 32'd1);
        chk({tag, "_rdy1"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data = px;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_ov_early"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy_full"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(exp));
        chk({tag, "_last"}, 32'(out_last), 32'd1);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_d"}, 32'(busy), 32'd1);
        chk({tag, "_ov_gone"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int in_i, out_i, outs, dones, ins;
        logic prev_stall;
        logic [7:0] prev_data;

        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        num_pixels = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;

        // Reset values
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-pixel frames with hand-computed gray values
        run_single("px_white", 24'hFFFFFF, 8'd255);
        run_single("px_red",   24'h0000FF, 8'd76);
        run_single("px_green", 24'h00FF00, 8'd149);
        run_single("px_blue",  24'hFF0000, 8'd29);
        run_single("px_black", 24'h000000, 8'd0);

        // Streaming frame of 16 pixels at full rate
        for (int i = 0; i < 16; i++) begin
            spix[i] = {8'(i * 13 + 200), 8'(i * 91 + 5), 8'(i * 37)};
        end
        @(negedge clk);
        start = 1'b1;
        num_pixels = 20'd16;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk("st_busy", 32'(busy), 32'd1);
            chk("st_in_ready", 32'(in_ready), 32'(c <= 16));
            chk("st_out_valid", 32'(out_valid), 32'(c >= 3 && c <= 18));
            chk("st_done", 32'(done), 32'(c == 19));
            if (c >= 3 && c <= 18) begin
                chk("st_data", 32'(out_data), 32'(gray_of(spix[c - 3])));
                chk("st_last", 32'(out_last), 32'(c == 18));
            end
            in_valid = (c <= 17);
            if (c <= 16) in_data = spix[c - 1];
        end
        @(negedge clk);
        chk("st_end_busy", 32'(busy), 32'd0);
        chk("st_end_done", 32'(done), 32'd0);

        // Backpressure frame of 8 pixels with random stalls and input gaps
        for (int i = 0; i < 8; i++) bpix[i] = 24'($urandom);
        @(negedge clk);
        start = 1'b1;
        num_pixels = 20'd8;
        @(negedge clk);
        start = 1'b0;
        in_i = 0;
        out_i = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 300 && out_i < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (in_i < 8) && ($urandom_range(0, 3) != 0);
            in_data = bpix[(in_i < 8) ? in_i : 7];
            #1;
            if (prev_stall) begin
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && !out_ready) chk("bp_in_ready_stall", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                chk("bp_data", 32'(out_data), 32'(gray_of(bpix[out_i])));
                chk("bp_last", 32'(out_last), 32'(out_i == 7));
                out_i++;
            end
            if (in_valid && in_ready) in_i++;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
        chk("bp_out_count", 32'(out_i), 32'd8);
        chk("bp_in_count", 32'(in_i), 32'd8);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b0;
        chk("bp_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("bp_idle", 32'(busy), 32'd0);

        // Zero-length frame
        start = 1'b1;
        num_pixels = 20'd0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd1);
        chk("zero_in_ready", 32'(in_ready), 32'd0);
        chk("zero_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("zero_done_off", 32'(done), 32'd0);
        chk("zero_idle_ready", 32'(in_ready), 32'd0);
        chk("zero_idle_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;

        // Start while busy is ignored: a 2-pixel frame must not grow to 5
        start = 1'b1;
        num_pixels = 20'd2;
        @(negedge clk);
        num_pixels = 20'd5;
        in_valid = 1'b1;
        in_data = 24'h00FF00;
        @(negedge clk);
        chk("ign_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("ign_full", 32'(in_ready), 32'd0);
        chk("ign_ov1", 32'(out_valid), 32'd1);
        chk("ign_last1", 32'(out_last), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ign_ov2", 32'(out_valid), 32'd1);
        chk("ign_last2", 32'(out_last), 32'd1);
        chk("ign_data2", 32'(out_data), 32'd149);
        @(negedge clk);
        chk("ign_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("ign_idle", 32'(busy), 32'd0);
        chk("ign_no_more", 32'(out_valid), 32'd0);

        // Reset in the middle of a 10-pixel frame
        start = 1'b1;
        num_pixels = 20'd10;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 24'hFFFFFF;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_ov_before", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_out_data", 32'(out_data), 32'd0);
        chk("mid_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        num_pixels = 20'd2;
        outs = 0;
        dones = 0;
        ins = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b1;
            in_data = 24'h0000FF;
            #1;
            if (in_valid && in_ready) ins++;
            if (out_valid && out_ready) begin
                outs++;
                chk("post_data", 32'(out_data), 32'd76);
                chk("post_last", 32'(out_last), 32'(outs == 2));
            end
            if (done) dones++;
        end
        in_valid = 1'b0;
        chk("post_in_count", 32'(ins), 32'd2);
        chk("post_out_count", 32'(outs), 32'd2);
        chk("post_done_count", 32'(dones), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
